// File: rtl/tdm_demux.sv
// Receive side of the slot-multiplexed link: splits one TDM lane back into N_CH
// held channel registers, with frame lock tracking and framing-error reporting.
module tdm_demux #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      din,
    input  logic               din_vld,
    input  logic               din_sof,
    output logic [N_CH*DW-1:0] ch_data,
    output logic [N_CH-1:0]    ch_upd,
    output logic               frame_done,
    output logic               frame_err,
    output logic               locked
);

    localparam int unsigned    CW   = $clog2(N_CH);
    localparam logic [CW-1:0]  LAST = CW'(N_CH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    typedef enum logic [1:0] {
        Hunt,
        Recv,
        Wait
    } state_t;

    state_t        state;
    logic [CW-1:0] slot_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= Hunt;
            slot_cnt   <= '0;
            ch_data    <= '0;
            ch_upd     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            ch_upd     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (din_vld) begin
                case (state)
                    Hunt: begin
                        // Non-SOF slots are dropped silently until a frame start is seen.
                        if (din_sof) begin
                            ch_data[0 +: DW] <= din;
                            ch_upd[0]        <= 1'b1;
                            slot_cnt         <= ONE;
                            state            <= Recv;
                        end
                    end
                    Recv: begin
                        if (din_sof) begin
                            // Early SOF restarts the frame; earlier channel writes stand.
                            frame_err        <= 1'b1;
                            locked           <= 1'b0;
                            ch_data[0 +: DW] <= din;
                            ch_upd[0]        <= 1'b1;
                            slot_cnt         <= ONE;
                        end else begin
                            ch_data[int'(slot_cnt)*DW +: DW] <= din;
                            ch_upd[slot_cnt]                 <= 1'b1;
                            if (slot_cnt == LAST) begin
                                frame_done <= 1'b1;
                                locked     <= 1'b1;
                                slot_cnt   <= '0;
                                state      <= Wait;
                            end else begin
                                slot_cnt <= slot_cnt + ONE;
                            end
                        end
                    end
                    Wait: begin
                        if (din_sof) begin
                            ch_data[0 +: DW] <= din;
                            ch_upd[0]        <= 1'b1;
                            slot_cnt         <= ONE;
                            state            <= Recv;
                        end else begin
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            state     <= Hunt;
                        end
                    end
                    default: begin
                        state    <= Hunt;
                        slot_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random traffic,
// compared against a slot-position reference model.
module tb_tdm_demux;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DW   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [DW-1:0]      din = '0;
    logic               din_vld = 1'b0;
    logic               din_sof = 1'b0;
    logic [N_CH*DW-1:0] ch_data;
    logic [N_CH-1:0]    ch_upd;
    logic               frame_done;
    logic               frame_err;
    logic               locked;

    int total = 0;
    int bad   = 0;

    tdm_demux #(.N_CH(N_CH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_vld    (din_vld),
        .din_sof    (din_sof),
        .ch_data    (ch_data),
        .ch_upd     (ch_upd),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Reference model: pos = index of the next expected slot; -1 = hunting,
    // N_CH = a full frame has arrived and the next slot must be a SOF.
    logic [DW-1:0]   m_ch [N_CH];
    logic [N_CH-1:0] m_upd;
    logic            m_done, m_err, m_locked;
    int              pos;

    function automatic logic [N_CH*DW-1:0] m_data();
        logic [N_CH*DW-1:0] r;
        for (int i = 0; i < N_CH; i++) r[i*DW +: DW] = m_ch[i];
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) m_ch[i] = '0;
        m_upd = '0; m_done = 0; m_err = 0; m_locked = 0; pos = -1;
    endfunction

    function automatic void model_step(input logic v, input logic s, input logic [DW-1:0] d);
        m_upd = '0; m_done = 0; m_err = 0;
        if (!v) return;
        if (s) begin
            if (pos > 0 && pos < N_CH) begin
                m_err = 1; m_locked = 0;
            end
            m_ch[0] = d; m_upd[0] = 1'b1; pos = 1;
        end else if (pos == N_CH) begin
            m_err = 1; m_locked = 0; pos = -1;
        end else if (pos >= 0) begin
            m_ch[pos] = d; m_upd[pos] = 1'b1; pos++;
            if (pos == N_CH) begin
                m_done = 1; m_locked = 1;
            end
        end
    endfunction

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        @(negedge clk);
        din_vld = v; din_sof = s; din = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_vld = 0; din_sof = 0; rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ch_data, ch_upd, frame_done, frame_err, locked} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got data=%h upd=%b done=%b err=%b lock=%b want all 0",
                     ch_data, ch_upd, frame_done, frame_err, locked);
        end
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] f [N_CH];
        f[0] = 8'h11; f[1] = 8'h22; f[2] = 8'h33; f[3] = 8'h44;
        for (int i = 0; i < N_CH; i++) begin
            drive(1, i == 0, f[i]);
            total++;
            if (ch_upd !== (N_CH'(1) << i) || ch_upd !== m_upd) begin
                bad++;
                $display("FAIL single_upd slot=%0d got=%b want=%b", i, ch_upd, m_upd);
            end
            total++;
            if (frame_done !== (i == N_CH - 1) || frame_err !== 1'b0) begin
                bad++;
                $display("FAIL single_done slot=%0d got done=%b err=%b want done=%b err=0",
                         i, frame_done, frame_err, i == N_CH - 1);
            end
        end
        total++;
        if (ch_data !== 32'h44332211 || locked !== 1'b1) begin
            bad++;
            $display("FAIL single_data got=%h lock=%b want=44332211 lock=1", ch_data, locked);
        end
        drive(0, 0, 0);
        total++;
        if (frame_done !== 1'b0 || ch_upd !== '0) begin
            bad++;
            $display("FAIL single_pulse_width got done=%b upd=%b want 0", frame_done, ch_upd);
        end
    endtask

    task automatic test_hunt_discard();
        do_reset();
        drive(1, 0, 8'hAA);
        drive(1, 0, 8'hBB);
        total++;
        if (ch_data !== '0 || ch_upd !== '0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL hunt_discard got data=%h upd=%b err=%b want 0", ch_data, ch_upd, frame_err);
        end
        for (int i = 0; i < N_CH; i++) drive(1, i == 0, DW'(i + 1));
        total++;
        if (ch_data !== 32'h04030201 || locked !== 1'b1) begin
            bad++;
            $display("FAIL hunt_frame got=%h lock=%b want=04030201 lock=1", ch_data, locked);
        end
    endtask

    task automatic test_early_sof();
        drive(1, 1, 8'h55);
        drive(1, 0, 8'h66);
        drive(1, 1, 8'h77);
        total++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || ch_upd !== 4'b0001) begin
            bad++;
            $display("FAIL early_err got err=%b lock=%b upd=%b want err=1 lock=0 upd=0001",
                     frame_err, locked, ch_upd);
        end
        drive(1, 0, 8'h88);
        drive(1, 0, 8'h99);
        drive(1, 0, 8'hAA);
        total++;
        if (ch_data !== 32'hAA998877 || frame_done !== 1'b1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL early_final got=%h done=%b lock=%b want=AA998877 done=1 lock=1",
                     ch_data, frame_done, locked);
        end
    endtask

    task automatic test_missing_sof();
        logic [N_CH*DW-1:0] held;
        for (int i = 0; i < N_CH; i++) drive(1, i == 0, DW'($urandom));
        held = m_data();
        total++;
        if (ch_data !== held || locked !== 1'b1) begin
            bad++;
            $display("FAIL miss_frame got=%h lock=%b want=%h lock=1", ch_data, locked, held);
        end
        drive(1, 0, 8'hEE);
        total++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || ch_upd !== '0 || ch_data !== held) begin
            bad++;
            $display("FAIL miss_err got err=%b lock=%b upd=%b data=%h want err=1 lock=0 upd=0 data=%h",
                     frame_err, locked, ch_upd, ch_data, held);
        end
        drive(1, 0, 8'h5A);
        total++;
        if (frame_err !== 1'b0 || ch_upd !== '0 || ch_data !== held) begin
            bad++;
            $display("FAIL miss_hunt got err=%b upd=%b data=%h want err=0 upd=0 data=%h",
                     frame_err, ch_upd, ch_data, held);
        end
    endtask

    task automatic test_gaps_back_to_back();
        logic [DW-1:0]      f1 [N_CH];
        logic [DW-1:0]      f2 [N_CH];
        logic [N_CH*DW-1:0] want;
        int n_done = 0;
        int n_err  = 0;
        int n_mis  = 0;
        do_reset();
        for (int i = 0; i < N_CH; i++) begin
            f1[i] = DW'($urandom); f2[i] = DW'($urandom);
        end
        for (int i = 0; i < N_CH; i++) begin
            drive(1, i == 0, f1[i]);
            n_done += int'(frame_done); n_err += int'(frame_err);
            if ({ch_data, ch_upd, frame_done, locked} !== {m_data(), m_upd, m_done, m_locked}) n_mis++;
            if (i != N_CH - 1) begin
                for (int g = 0; g < 3; g++) begin
                    drive(0, 0, DW'($urandom));
                    n_err += int'(frame_err);
                    if (ch_upd !== '0 || frame_done !== 1'b0) n_mis++;
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            drive(1, i == 0, f2[i]);
            n_done += int'(frame_done); n_err += int'(frame_err);
            if ({ch_data, ch_upd, frame_done, locked} !== {m_data(), m_upd, m_done, m_locked}) n_mis++;
        end
        for (int i = 0; i < N_CH; i++) want[i*DW +: DW] = f2[i];
        total++;
        if (n_done !== 2 || n_err !== 0 || n_mis !== 0) begin
            bad++;
            $display("FAIL gaps_counts got done=%0d err=%0d cyc_mis=%0d want done=2 err=0 cyc_mis=0",
                     n_done, n_err, n_mis);
        end
        total++;
        if (ch_data !== want || locked !== 1'b1) begin
            bad++;
            $display("FAIL gaps_data got=%h lock=%b want=%h lock=1", ch_data, locked, want);
        end
    endtask

    task automatic test_reset_mid_frame();
        drive(1, 1, 8'h12);
        drive(1, 0, 8'h34);
        @(negedge clk);
        din_vld = 0; din_sof = 0;
        rst = 1;
        #1;
        total++;
        if ({ch_data, ch_upd, frame_done, frame_err, locked} !== '0) begin
            bad++;
            $display("FAIL rst_async got data=%h upd=%b done=%b err=%b lock=%b want all 0",
                     ch_data, ch_upd, frame_done, frame_err, locked);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        drive(1, 0, 8'h56);
        total++;
        if (ch_data !== '0 || ch_upd !== '0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_hunt got data=%h upd=%b err=%b want 0", ch_data, ch_upd, frame_err);
        end
        drive(1, 1, 8'hC1);
        drive(1, 0, 8'hC2);
        drive(1, 0, 8'hC3);
        drive(1, 0, 8'hC4);
        total++;
        if (ch_data !== 32'hC4C3C2C1 || locked !== 1'b1 || frame_done !== 1'b1) begin
            bad++;
            $display("FAIL rst_frame got=%h lock=%b done=%b want=C4C3C2C1 lock=1 done=1",
                     ch_data, locked, frame_done);
        end
    endtask

    task automatic test_random();
        int n_mis = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, DW'($urandom));
            if ({ch_data, ch_upd, frame_done, frame_err, locked} !==
                {m_data(), m_upd, m_done, m_err, m_locked}) begin
                n_mis++;
                if (n_mis <= 5)
                    $display("FAIL random_cycle c=%0d got data=%h upd=%b d=%b e=%b l=%b want data=%h upd=%b d=%b e=%b l=%b",
                             c, ch_data, ch_upd, frame_done, frame_err, locked,
                             m_data(), m_upd, m_done, m_err, m_locked);
            end
        end
        total++;
        if (n_mis != 0) begin
            bad++;
            $display("FAIL random_total got mismatched_cycles=%0d want 0", n_mis);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_hunt_discard();
        test_early_sof();
        test_missing_sof();
        test_gaps_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
